pe_stream_arb: RTL and testbench

PE_STREAM_ARB -- requirements
Module: pe_stream_arb

---
 rtl/pe_stream_arb_pkg.sv | 17 +
 rtl/pe_stream_arb_if.sv | 25 ++
 rtl/pe_axis_skid.sv | 64 ++++++
 rtl/pe_stream_arb.sv | 158 +++++++++++++++
 tb/tb_pe_stream_arb.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_stream_arb_pkg.sv
// Shared types for the two-source AXI4-Stream packet arbiter.
// Holds the FSM state encoding, source id type and skid depth.
package pe_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    XFER0,
    XFER1,
    DRAIN
  } state_t;

  typedef logic src_id_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/pe_stream_arb_if.sv
// AXI4-Stream bundle for the arbiter; master drives, slave accepts.
// Sources carry no id; the arbiter attaches tid on the output side.
interface pe_stream_arb_if #(
  parameter int DW = 256
);
  import pe_arb_pkg::*;

  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  src_id_t         tid;

  modport master (
    output tvalid, tdata, tkeep, tlast, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tlast,
    output tready
  );

endinterface

// File: rtl/pe_axis_skid.sv
// Two-entry AXIS skid FIFO carrying data, keep, last and source id.
// Registered output: one cycle from acceptance to tvalid.
module pe_axis_skid
  import pe_arb_pkg::*;
#(
  parameter int DW = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   in_data_i,
  input  logic [DW/8-1:0] in_keep_i,
  input  logic            in_last_i,
  input  src_id_t         in_id_i,
  output logic            empty_o,
  pe_stream_arb_if.master m
);

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] keep;
    logic            last;
    src_id_t         id;
  } beat_t;

  beat_t      mem_q [SKID_DEPTH];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       push;
  logic       pop;
  beat_t      head;

  assign in_ready_o = (cnt_q != 2'(SKID_DEPTH));
  assign empty_o    = (cnt_q == 2'd0);
  assign push       = in_valid_i & in_ready_o;
  assign pop        = m.tvalid & m.tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wr_q <= ~wr_q;
      if (pop)  rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{in_data_i, in_keep_i, in_last_i, in_id_i};
  end

  assign head     = mem_q[rd_q];
  assign m.tvalid = ~empty_o;
  assign m.tdata  = head.data;
  assign m.tkeep  = head.keep;
  assign m.tlast  = head.last;
  assign m.tid    = head.id;

endmodule

// File: rtl/pe_stream_arb.sv
// Packet-locked two-source AXIS arbiter (round-robin or strict priority).
// Optional perf counters enabled by defining PE_STREAM_ARB_PERF_EN.
module pe_stream_arb
  import pe_arb_pkg::*;
#(
  parameter int C_TDATA_WIDTH = 256,
  parameter int C_CNT_WIDTH   = 32
) (
  input  logic                   ap_clk,
  input  logic                   areset,
  input  logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic                   ctrl_prio,
  input  logic [C_CNT_WIDTH-1:0] ctrl_pkts0,
  input  logic [C_CNT_WIDTH-1:0] ctrl_pkts1,
  pe_stream_arb_if.slave         s0_axis,
  pe_stream_arb_if.slave         s1_axis,
  pe_stream_arb_if.master        m_axis
`ifdef PE_STREAM_ARB_PERF_EN
  ,
  output logic [31:0]            perf_beats0,
  output logic [31:0]            perf_beats1,
  output logic [31:0]            perf_stall
`endif
);

  state_t                 state_q, state_d;
  logic [C_CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt0_dec;
  logic [C_CNT_WIDTH-1:0] cnt1_q, cnt1_d, cnt1_dec;
  src_id_t                rr_q, rr_d;
  logic                   prio_q, prio_d;
  logic                   start_q;
  logic                   start_edge;
  logic                   fire0, fire1;
  logic                   dec0, dec1;
  logic                   req0, req1;
  logic                   gnt_ok;
  src_id_t                gnt_id;
  logic                   sk_ready, sk_empty, sel1;

  assign start_edge = ap_start & ~start_q;
  assign fire0 = s0_axis.tvalid & s0_axis.tready;
  assign fire1 = s1_axis.tvalid & s1_axis.tready;
  assign dec0  = fire0 & s0_axis.tlast & (cnt0_q != '0);
  assign dec1  = fire1 & s1_axis.tlast & (cnt1_q != '0);
  assign cnt0_dec = cnt0_q - C_CNT_WIDTH'(dec0);
  assign cnt1_dec = cnt1_q - C_CNT_WIDTH'(dec1);

  // Eligibility sees post-tlast counts so back-to-back grants stay exact.
  assign req0   = (cnt0_dec != '0) & s0_axis.tvalid;
  assign req1   = (cnt1_dec != '0) & s1_axis.tvalid;
  assign gnt_ok = req0 | req1;
  assign gnt_id = prio_q ? ~req0 : ((req0 & req1) ? ~rr_q : req1);

  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_dec;
    cnt1_d  = cnt1_dec;
    rr_d    = rr_q;
    prio_d  = prio_q;
    ap_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = ARB;
          cnt0_d  = ctrl_pkts0;
          cnt1_d  = ctrl_pkts1;
          prio_d  = ctrl_prio;
          rr_d    = 1'b1;
        end
      end
      ARB: begin
        if (cnt0_q == '0 && cnt1_q == '0) begin
          state_d = DRAIN;
        end else if (gnt_ok) begin
          state_d = gnt_id ? XFER1 : XFER0;
          rr_d    = gnt_id;
        end
      end
      XFER0, XFER1: begin
        if (dec0 | dec1) begin
          if (gnt_ok) begin
            state_d = gnt_id ? XFER1 : XFER0;
            rr_d    = gnt_id;
          end else begin
            state_d = ARB;
          end
        end
      end
      DRAIN: begin
        if (sk_empty) begin
          state_d = IDLE;
          ap_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      rr_q    <= 1'b1;
      prio_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      rr_q    <= rr_d;
      prio_q  <= prio_d;
      start_q <= ap_start;
    end
  end

  assign ap_idle = (state_q == IDLE);
  assign sel1    = (state_q == XFER1);
  assign s0_axis.tready = (state_q == XFER0) & sk_ready;
  assign s1_axis.tready = sel1 & sk_ready;

  pe_axis_skid #(
    .DW(C_TDATA_WIDTH)
  ) u_skid (
    .clk        (ap_clk),
    .rst        (areset),
    .in_valid_i (fire0 | fire1),
    .in_ready_o (sk_ready),
    .in_data_i  (sel1 ? s1_axis.tdata : s0_axis.tdata),
    .in_keep_i  (sel1 ? s1_axis.tkeep : s0_axis.tkeep),
    .in_last_i  (sel1 ? s1_axis.tlast : s0_axis.tlast),
    .in_id_i    (sel1),
    .empty_o    (sk_empty),
    .m          (m_axis)
  );

`ifdef PE_STREAM_ARB_PERF_EN
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      perf_beats0 <= '0;
      perf_beats1 <= '0;
      perf_stall  <= '0;
    end else if (ap_idle & start_edge) begin
      perf_beats0 <= '0;
      perf_beats1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (fire0) perf_beats0 <= perf_beats0 + 32'd1;
      if (fire1) perf_beats1 <= perf_beats1 + 32'd1;
      if (m_axis.tvalid & ~m_axis.tready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_stream_arb.sv
// Directed + randomized bench for pe_stream_arb with a packet-order model.
// Perf counter checks compile only with PE_STREAM_ARB_PERF_EN.
module tb_pe_stream_arb;
  import pe_arb_pkg::*;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          id;
  } beat_t;

  logic          clk = 1'b0;
  logic          areset;
  logic          ap_start;
  logic          ap_idle;
  logic          ap_done;
  logic          ctrl_prio;
  logic [CW-1:0] ctrl_pkts0;
  logic [CW-1:0] ctrl_pkts1;
`ifdef PE_STREAM_ARB_PERF_EN
  logic [31:0]   perf_beats0, perf_beats1, perf_stall;
`endif

  pe_stream_arb_if #(.DW(DW)) s0_if ();
  pe_stream_arb_if #(.DW(DW)) s1_if ();
  pe_stream_arb_if #(.DW(DW)) m_if ();

  always #5 clk = ~clk;

  pe_stream_arb #(
    .C_TDATA_WIDTH(DW),
    .C_CNT_WIDTH  (CW)
  ) dut (
    .ap_clk     (clk),
    .areset     (areset),
    .ap_start   (ap_start),
    .ap_idle    (ap_idle),
    .ap_done    (ap_done),
    .ctrl_prio  (ctrl_prio),
    .ctrl_pkts0 (ctrl_pkts0),
    .ctrl_pkts1 (ctrl_pkts1),
    .s0_axis    (s0_if),
    .s1_axis    (s1_if),
    .m_axis     (m_if)
`ifdef PE_STREAM_ARB_PERF_EN
    ,
    .perf_beats0(perf_beats0),
    .perf_beats1(perf_beats1),
    .perf_stall (perf_stall)
`endif
  );

  beat_t q0[$];
  beat_t q1[$];
  beat_t expq[$];
  int    n_assert = 0;
  int    n_fail = 0;
  int    n_done, cyc, trmode;
  int    nout, first_out, last_out, acc0, acc1, stall_cnt;
  logic  stall_prev;
  beat_t stall_beat;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mkbeat(input logic id, input logic last);
    beat_t b;
    for (int i = 0; i < DW / 32; i++) b.data[i*32+:32] = $urandom;
    b.keep = $urandom;
    b.last = last;
    b.id   = id;
    return b;
  endfunction

  task automatic drive();
    beat_t b0, b1;
    b0 = '0;
    b1 = '0;
    if (q0.size() > 0) b0 = q0[0];
    if (q1.size() > 0) b1 = q1[0];
    s0_if.tvalid = (q0.size() > 0);
    s0_if.tdata  = b0.data;
    s0_if.tkeep  = b0.keep;
    s0_if.tlast  = b0.last;
    s1_if.tvalid = (q1.size() > 0);
    s1_if.tdata  = b1.data;
    s1_if.tkeep  = b1.keep;
    s1_if.tlast  = b1.last;
    case (trmode)
      0:       m_if.tready = 1'b1;
      2:       m_if.tready = cyc[0];
      default: m_if.tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Sample at negedge, advance sources just after the rising edge.
  task automatic cycle();
    logic  f0, f1, fm;
    beat_t ob, e;
    @(negedge clk);
    cyc++;
    f0 = s0_if.tvalid & s0_if.tready;
    f1 = s1_if.tvalid & s1_if.tready;
    fm = m_if.tvalid & m_if.tready;
    if (ap_done) n_done++;
    ob = '{m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid};
    if (stall_prev) begin
      chk("stall_valid", 512'(m_if.tvalid), 512'(1));
      chk("stall_hold", 512'(ob), 512'(stall_beat));
    end
    stall_prev = m_if.tvalid & ~m_if.tready;
    stall_beat = ob;
    if (stall_prev) stall_cnt++;
    if (fm) begin
      e = 'x;
      if (expq.size() > 0) e = expq.pop_front();
      chk("out_beat", 512'(ob), 512'(e));
      if (nout == 0) first_out = cyc;
      last_out = cyc;
      nout++;
    end
    @(posedge clk);
    #1;
    if (f0) begin void'(q0.pop_front()); acc0++; end
    if (f1) begin void'(q1.pop_front()); acc1++; end
    drive();
  endtask

  // Model: packet order from arbitration rules with both sources backlogged.
  task automatic load(input logic p, input int n0, input int n1,
                      input int flen, input int mode);
    int   len, i0, i1, o0, o1;
    logic lastg, s;
    q0.delete();
    q1.delete();
    expq.delete();
    for (int k = 0; k < n0; k++) begin
      len = (flen > 0) ? flen : int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) q0.push_back(mkbeat(1'b0, b == len - 1));
    end
    for (int k = 0; k < n1; k++) begin
      len = (flen > 0) ? flen : int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) q1.push_back(mkbeat(1'b1, b == len - 1));
    end
    i0 = 0; i1 = 0; o0 = n0; o1 = n1; lastg = 1'b1;
    while (o0 + o1 > 0) begin
      if (p || o0 == 0 || o1 == 0) s = (o0 == 0);
      else s = ~lastg;
      lastg = s;
      if (!s) begin
        o0--;
        do begin expq.push_back(q0[i0]); i0++; end while (!q0[i0-1].last);
      end else begin
        o1--;
        do begin expq.push_back(q1[i1]); i1++; end while (!q1[i1-1].last);
      end
    end
    ctrl_prio  = p;
    ctrl_pkts0 = CW'(n0);
    ctrl_pkts1 = CW'(n1);
    trmode     = mode;
    n_done = 0; nout = 0; acc0 = 0; acc1 = 0; stall_cnt = 0;
    stall_prev = 1'b0;
    drive();
  endtask

  task automatic start();
    ap_start = 1'b1;
    cycle();
    chk("idle_low", 512'(ap_idle), 512'(0));
    cycle();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!(n_done > 0 && ap_idle) && k < 3000) begin
      cycle();
      k++;
    end
    chk({tag, "_timeout"}, 512'(k < 3000), 512'(1));
    chk({tag, "_done_cnt"}, 512'(n_done), 512'(1));
    chk({tag, "_exp_left"}, 512'(expq.size()), 512'(0));
    chk({tag, "_src_left"}, 512'(q0.size() + q1.size()), 512'(0));
    chk({tag, "_idle"}, 512'(ap_idle), 512'(1));
  endtask

  initial begin
    int k;
    areset = 1'b1; ap_start = 1'b0; ctrl_prio = 1'b0;
    ctrl_pkts0 = '0; ctrl_pkts1 = '0; cyc = 0; trmode = 0;
    s0_if.tid = 1'b0; s1_if.tid = 1'b1;
    stall_prev = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_idle", 512'(ap_idle), 512'(1));
    chk("rst_done", 512'(ap_done), 512'(0));
    chk("rst_tready", 512'({s0_if.tready, s1_if.tready}), 512'(0));
    chk("rst_mvalid", 512'(m_if.tvalid), 512'(0));
    areset = 1'b0;
    cycle();

    load(1'b0, 2, 2, 4, 0);
    start();
    wait_done("rr");
    chk("rr_beats", 512'(nout), 512'(16));
    chk("rr_span", 512'(last_out - first_out + 1), 512'(16));

    load(1'b1, 3, 1, 0, 0);
    start();
    wait_done("prio");

    load(1'b0, 0, 0, 0, 0);
    q0.push_back(mkbeat(1'b0, 1'b1));
    q1.push_back(mkbeat(1'b1, 1'b1));
    drive();
    ap_start = 1'b1;
    cycle();
    chk("zero_idle", 512'(ap_idle), 512'(0));
    chk("zero_done1", 512'(ap_done), 512'(0));
    chk("zero_rdy1", 512'({s0_if.tready, s1_if.tready}), 512'(0));
    cycle();
    chk("zero_done2", 512'(ap_done), 512'(1));
    chk("zero_rdy2", 512'({s0_if.tready, s1_if.tready}), 512'(0));
    cycle();
    chk("zero_done3", 512'(ap_done), 512'(0));
    chk("zero_idle_back", 512'(ap_idle), 512'(1));
    chk("zero_acc", 512'(acc0 + acc1), 512'(0));
    ap_start = 1'b0;
    q0.delete();
    q1.delete();
    drive();
    cycle();

    load(1'b0, 0, 1, 8, 2);
    start();
    wait_done("bp");
    chk("bp_beats", 512'(nout), 512'(8));
`ifdef PE_STREAM_ARB_PERF_EN
    chk("bp_perf_beats1", 512'(perf_beats1), 512'(8));
    chk("bp_perf_beats0", 512'(perf_beats0), 512'(0));
    chk("bp_perf_stall", 512'(perf_stall), 512'(stall_cnt));
`endif

    load(1'b0, 1, 0, 6, 0);
    start();
    k = 0;
    while (acc0 < 3 && k < 100) begin
      cycle();
      k++;
    end
    chk("rst_mid_beats", 512'(acc0), 512'(3));
    areset = 1'b1;
    stall_prev = 1'b0;
    cycle();
    chk("rst_mid_mvalid", 512'(m_if.tvalid), 512'(0));
    chk("rst_mid_idle", 512'(ap_idle), 512'(1));
    chk("rst_mid_tready", 512'(s0_if.tready), 512'(0));
    areset = 1'b0;
    q0.delete();
    expq.delete();
    drive();
    cycle();
    load(1'b0, 2, 1, 0, 1);
    start();
    wait_done("post_rst");

    for (int t = 0; t < 6; t++) begin
      load(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), 0, 1);
      start();
      wait_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
